// File: rtl/tug_pkg.sv
// tug_pkg -- shared types and constants for the tug-of-war playfield.
//
// Holds the round-state enum, the playfield geometry and the winning score,
// plus two small decode helpers used to build the registered outputs.
// The optional score displays are enabled by the TUG_HEX_EN macro in
// tug_playfield; nothing in this package depends on it.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    LWON = 2'd1,
    RWON = 2'd2,
    OVER = 2'd3
  } tug_state_e;

  localparam int NUM_LIGHTS = 9;
  localparam int CENTER_POS = 4;
  localparam int WIN_SCORE  = 7;

  localparam logic [3:0] LAST_POS   = 4'(NUM_LIGHTS - 1);
  localparam logic [3:0] CENTER_IDX = 4'(CENTER_POS);
  localparam logic [2:0] WIN_COUNT  = 3'(WIN_SCORE);

  // The playfield only shows the light while a round is in progress;
  // between rounds and after the match the whole row goes dark.
  function automatic logic [NUM_LIGHTS-1:0] lightsFor(input tug_state_e st,
                                                      input logic [3:0] pos);
    logic [NUM_LIGHTS-1:0] one;
    one = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
    lightsFor = (st == PLAY) ? (one << pos) : '0;
  endfunction

  function automatic logic [1:0] winnerFor(input tug_state_e st);
    case (st)
      LWON:    winnerFor = 2'b01;
      RWON:    winnerFor = 2'b10;
      OVER:    winnerFor = 2'b11;
      default: winnerFor = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/tug_playfield_seg7.sv
// seg7_score -- active-low 7-segment decoder for a 0..7 score.
//
// Ports:
//   Score  in  3  score value
//   Seg    out 7  segments {g,f,e,d,c,b,a}, 0 = segment lit
//
// Only instantiated by tug_playfield when TUG_HEX_EN is defined.
module seg7_score (
  input  logic [2:0] Score,
  output logic [6:0] Seg
);

  // Pure lookup; scores never exceed 7 so the table is complete.
  always_comb begin
    Seg = 7'b1111111;
    case (Score)
      3'd0: Seg = 7'b1000000;
      3'd1: Seg = 7'b1111001;
      3'd2: Seg = 7'b0100100;
      3'd3: Seg = 7'b0110000;
      3'd4: Seg = 7'b0011001;
      3'd5: Seg = 7'b0010010;
      3'd6: Seg = 7'b0000010;
      3'd7: Seg = 7'b1111000;
      default: Seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/tug_playfield.sv
// tug_playfield -- two-player tug-of-war light game.
//
// Ports:
//   Clock       in  1  system clock, rising edge
//   Reset       in  1  asynchronous active-high reset
//   LeftPulse   in  1  one-cycle press from the left player (already edge-detected)
//   RightPulse  in  1  one-cycle press from the right player (already edge-detected)
//   LEDR        out 9  playfield, LEDR[8] leftmost, one-hot or all-zero
//   LeftScore   out 3  left round wins
//   RightScore  out 3  right round wins
//   Winner      out 2  00 playing, 01 left won round, 10 right won round, 11 match over
//   HEX0, HEX5  out 7  active-low score digits (right, left); only with TUG_HEX_EN
//
// Configuration macro: TUG_HEX_EN adds the HEX0/HEX5 score displays.
// Every output comes straight from a register (the HEX digits are a
// combinational decode of the score registers).
module tug_playfield
  import tug_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       LeftPulse,
  input  logic       RightPulse,
  output logic [8:0] LEDR,
  output logic [2:0] LeftScore,
  output logic [2:0] RightScore,
  output logic [1:0] Winner
`ifdef TUG_HEX_EN
  ,
  output logic [6:0] HEX0,
  output logic [6:0] HEX5
`endif
);

  tug_state_e state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [2:0] lScore_q, lScore_d;
  logic [2:0] rScore_q, rScore_d;
  logic [NUM_LIGHTS-1:0] ledr_q;
  logic [1:0] winner_q;

  logic leftOnly;
  logic rightOnly;

  // Simultaneous presses cancel out, so only a lone press pulls the light.
  assign leftOnly  = LeftPulse & ~RightPulse;
  assign rightOnly = RightPulse & ~LeftPulse;

  // Next-state logic. A press that pulls the light past an end scores the
  // round; the seventh win ends the match instead of pausing the round.
  // Between rounds any press just restarts play at the centre.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    lScore_d = lScore_q;
    rScore_d = rScore_q;
    case (state_q)
      PLAY: begin
        if (leftOnly) begin
          if (pos_q == LAST_POS) begin
            lScore_d = lScore_q + 3'd1;
            state_d  = (lScore_d == WIN_COUNT) ? OVER : LWON;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end else if (rightOnly) begin
          if (pos_q == 4'd0) begin
            rScore_d = rScore_q + 3'd1;
            state_d  = (rScore_d == WIN_COUNT) ? OVER : RWON;
          end else begin
            pos_d = pos_q - 4'd1;
          end
        end
      end
      LWON, RWON: begin
        if (LeftPulse || RightPulse) begin
          state_d = PLAY;
          pos_d   = CENTER_IDX;
        end
      end
      default: ;
    endcase
  end

  // State and output registers. LEDR and Winner are registered from the
  // next state so they change on the same edge that samples the press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= PLAY;
      pos_q    <= CENTER_IDX;
      lScore_q <= 3'd0;
      rScore_q <= 3'd0;
      ledr_q   <= lightsFor(PLAY, CENTER_IDX);
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      lScore_q <= lScore_d;
      rScore_q <= rScore_d;
      ledr_q   <= lightsFor(state_d, pos_d);
      winner_q <= winnerFor(state_d);
    end
  end

  assign LEDR       = ledr_q;
  assign LeftScore  = lScore_q;
  assign RightScore = rScore_q;
  assign Winner     = winner_q;

`ifdef TUG_HEX_EN
  seg7_score uRightDigit (
    .Score (rScore_q),
    .Seg   (HEX0)
  );

  seg7_score uLeftDigit (
    .Score (lScore_q),
    .Seg   (HEX5)
  );
`endif

endmodule

// File: tb/tb_tug_playfield.sv
// tb_tug_playfield -- self-checking bench for tug_playfield.
//
// Directed table, hand-written corner sequences and a randomized run, all
// checked against a game-level model of the tug-of-war rules.
module tb_tug_playfield;

  logic       Clock;
  logic       Reset;
  logic       LeftPulse;
  logic       RightPulse;
  logic [8:0] LEDR;
  logic [2:0] LeftScore;
  logic [2:0] RightScore;
  logic [1:0] Winner;
`ifdef TUG_HEX_EN
  logic [6:0] HEX0;
  logic [6:0] HEX5;
`endif

  int testsRun;
  int testsFailed;

  // Game model: light position counted from the right, round result and
  // match-over flag kept as plain integers.
  int mPos;
  int mLeftWins;
  int mRightWins;
  int mRoundWinner;
  bit mMatchOver;

  tug_playfield dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .LeftPulse  (LeftPulse),
    .RightPulse (RightPulse),
    .LEDR       (LEDR),
    .LeftScore  (LeftScore),
    .RightScore (RightScore),
    .Winner     (Winner)
`ifdef TUG_HEX_EN
    ,
    .HEX0       (HEX0),
    .HEX5       (HEX5)
`endif
  );

  // 10 ns clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit         l;
    bit         r;
    logic [8:0] expLedr;
    logic [1:0] expWinner;
    logic [2:0] expLeft;
    logic [2:0] expRight;
  } vector_t;

  vector_t vecs[12];

  task automatic resetModel();
    mPos         = 4;
    mLeftWins    = 0;
    mRightWins   = 0;
    mRoundWinner = 0;
    mMatchOver   = 1'b0;
  endtask

  // One press cycle of the game rules.
  task automatic stepModel(input bit l, input bit r);
    if (mMatchOver) return;
    if (mRoundWinner != 0) begin
      if (l || r) begin
        mRoundWinner = 0;
        mPos = 4;
      end
      return;
    end
    if (l && !r) begin
      if (mPos == 8) begin
        mLeftWins++;
        if (mLeftWins == 7) mMatchOver = 1'b1;
        else mRoundWinner = 1;
      end else begin
        mPos++;
      end
    end else if (r && !l) begin
      if (mPos == 0) begin
        mRightWins++;
        if (mRightWins == 7) mMatchOver = 1'b1;
        else mRoundWinner = 2;
      end else begin
        mPos--;
      end
    end
  endtask

  function automatic logic [8:0] modelLedr();
    if (mMatchOver || mRoundWinner != 0) return 9'd0;
    return 9'(1 << mPos);
  endfunction

  function automatic logic [1:0] modelWinner();
    if (mMatchOver) return 2'd3;
    return 2'(mRoundWinner);
  endfunction

  function automatic logic [6:0] segFor(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      default: return 7'b1111000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] expLedr,
                             input logic [1:0] expWinner, input logic [2:0] expLeft,
                             input logic [2:0] expRight);
    testsRun++;
    if (LEDR !== expLedr || Winner !== expWinner ||
        LeftScore !== expLeft || RightScore !== expRight) begin
      testsFailed++;
      $display("[TB] FAIL %s: got LEDR=%b Winner=%b L=%0d R=%0d, expected LEDR=%b Winner=%b L=%0d R=%0d",
               name, LEDR, Winner, LeftScore, RightScore,
               expLedr, expWinner, expLeft, expRight);
    end
`ifdef TUG_HEX_EN
    testsRun++;
    if (HEX0 !== segFor(int'(expRight)) || HEX5 !== segFor(int'(expLeft))) begin
      testsFailed++;
      $display("[TB] FAIL %s hex: got HEX0=%b HEX5=%b, expected HEX0=%b HEX5=%b",
               name, HEX0, HEX5, segFor(int'(expRight)), segFor(int'(expLeft)));
    end
`endif
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, modelLedr(), modelWinner(), 3'(mLeftWins), 3'(mRightWins));
  endtask

  // Drive one cycle of pulses (called just after a posedge), clock it in
  // and leave the bench 1 ns after the sampling edge.
  task automatic applyStimulus(input bit l, input bit r);
    LeftPulse  = l;
    RightPulse = r;
    @(posedge Clock);
    #1;
    stepModel(l, r);
    LeftPulse  = 1'b0;
    RightPulse = 1'b0;
  endtask

  task automatic pressAndCheck(input string name, input bit l, input bit r);
    applyStimulus(l, r);
    checkModel(name);
  endtask

  // Asynchronous reset pulse placed well between clock edges.
  task automatic doReset(input string name);
    #2;
    Reset = 1'b1;
    #1;
    resetModel();
    checkOutput(name, 9'b000010000, 2'b00, 3'd0, 3'd0);
    Reset = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    Reset       = 1'b0;
    LeftPulse   = 1'b0;
    RightPulse  = 1'b0;
    resetModel();

    vecs[0]  = '{1, 0, 9'b000100000, 2'b00, 3'd0, 3'd0};
    vecs[1]  = '{1, 0, 9'b001000000, 2'b00, 3'd0, 3'd0};
    vecs[2]  = '{1, 0, 9'b010000000, 2'b00, 3'd0, 3'd0};
    vecs[3]  = '{1, 0, 9'b100000000, 2'b00, 3'd0, 3'd0};
    vecs[4]  = '{1, 0, 9'b000000000, 2'b01, 3'd1, 3'd0};
    vecs[5]  = '{0, 1, 9'b000010000, 2'b00, 3'd1, 3'd0};
    vecs[6]  = '{0, 1, 9'b000001000, 2'b00, 3'd1, 3'd0};
    vecs[7]  = '{1, 0, 9'b000010000, 2'b00, 3'd1, 3'd0};
    vecs[8]  = '{1, 1, 9'b000010000, 2'b00, 3'd1, 3'd0};
    vecs[9]  = '{1, 1, 9'b000010000, 2'b00, 3'd1, 3'd0};
    vecs[10] = '{1, 1, 9'b000010000, 2'b00, 3'd1, 3'd0};
    vecs[11] = '{0, 0, 9'b000010000, 2'b00, 3'd1, 3'd0};

    // Reset with the clock running, checked before any edge.
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("reset", 9'b000010000, 2'b00, 3'd0, 3'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Directed table: walk to the left end, win, restart, tie presses.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].l, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].expLedr, vecs[i].expWinner,
                  vecs[i].expLeft, vecs[i].expRight);
    end

    // Mid-round reset: three left wins, light at position 7.
    doReset("reset2");
    for (int w = 0; w < 3; w++) begin
      if (w != 0) pressAndCheck("restart", 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) pressAndCheck("leftrun", 1'b1, 1'b0);
    end
    pressAndCheck("restart", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) pressAndCheck("topos7", 1'b1, 1'b0);
    checkOutput("pos7", 9'b010000000, 2'b00, 3'd3, 3'd0);
    doReset("midreset");
    pressAndCheck("firstafter", 1'b1, 1'b0);
    checkOutput("firstafterconst", 9'b000100000, 2'b00, 3'd0, 3'd0);

    // Right player takes the match; then OVER ignores everything.
    doReset("reset3");
    for (int w = 0; w < 7; w++) begin
      if (w != 0) pressAndCheck("restart", 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) pressAndCheck("rightrun", 1'b0, 1'b1);
    end
    checkOutput("matchover", 9'b000000000, 2'b11, 3'd0, 3'd7);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("overhold", 9'b000000000, 2'b11, 3'd0, 3'd7);
    end

    // Randomized play with occasional resets, checked every cycle.
    doReset("reset4");
    for (int c = 0; c < 3000; c++) begin
      bit l, r;
      if ($urandom_range(0, 399) == 0) begin
        doReset("randreset");
      end else begin
        l = ($urandom_range(0, 99) < 45);
        r = ($urandom_range(0, 99) < 40);
        pressAndCheck("random", l, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/tug_playfield.md
TUG_PLAYFIELD -- requirements
Module: tug_playfield

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as the codebase does: Clock and Reset.
REQ-002 Clock  input  1  system clock; all state updates on posedge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 LeftPulse  input  1  one-cycle press pulse from the left player's debounced edge-detect stage.
REQ-005 RightPulse  input  1  one-cycle press pulse from the right player's debounced edge-detect stage.
REQ-006 LEDR  output  9  playfield lights; LEDR[8] is leftmost, LEDR[0] is rightmost; one-hot or all-zero.
REQ-007 LeftScore  output  3  left player's round wins, 0..7.
REQ-008 RightScore  output  3  right player's round wins, 0..7.
REQ-009 Winner  output  2  00 none, 01 left won round, 10 right won round, 11 match over.

Function
REQ-010 The state SHALL be a 4-bit position register (0..8, 0 = rightmost light) plus an FSM with states PLAY, LWON, RWON and OVER.
REQ-011 In PLAY: LeftPulse alone SHALL move position +1, RightPulse alone SHALL move it -1, and both or neither SHALL leave it unchanged.
REQ-012 In PLAY with position 8, a lone LeftPulse SHALL move to LWON and increment LeftScore; with position 0, a lone RightPulse SHALL move to RWON and increment RightScore.
REQ-013 All outputs SHALL be derived from registers only; a pulse sampled at edge n SHALL be reflected on the outputs immediately after edge n (latency 1).
REQ-014 LEDR SHALL be the one-hot decode of the position in PLAY and all-zero in LWON, RWON and OVER.
REQ-015 Winner SHALL be 01 in LWON, 10 in RWON, 11 in OVER and 00 in PLAY.
REQ-016 In LWON or RWON, the next edge with either pulse asserted SHALL return the FSM to PLAY with position 4 (centre); that pulse SHALL NOT move the light.
REQ-017 When an increment brings a score to 7, the FSM SHALL enter OVER instead of LWON or RWON.
REQ-018 OVER SHALL ignore all pulses until Reset; scores SHALL never wrap.
REQ-019 A pulse held high for k cycles SHALL be treated as k presses; the block SHALL NOT do any edge detection itself.

Reset
REQ-020 Reset assertion SHALL immediately force state PLAY, position 4, both scores 0, Winner 00 and LEDR 9'b000010000, regardless of the clock.
REQ-021 Reset asserted mid-round or in OVER SHALL discard all progress; the first pulse after deassertion SHALL be processed normally.

Configuration
REQ-022 Macro TUG_HEX_EN SHALL control the score displays.
REQ-023 With TUG_HEX_EN defined, the block SHALL add outputs HEX0[6:0] and HEX5[6:0], active-low 7-segment encodings of RightScore and LeftScore, combinationally decoded from the score registers.
REQ-024 Without TUG_HEX_EN, those ports and the decoders SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package tug_pkg SHALL hold the FSM enum (PLAY, LWON, RWON, OVER) and the constants NUM_LIGHTS=9, CENTER_POS=4 and WIN_SCORE=7.
REQ-026 The 7-segment decode SHALL be sub-module seg7_score (3-bit in, 7-bit active-low out), instantiated twice only under TUG_HEX_EN.

Verification
REQ-027 Reset, then 4 lone LeftPulse cycles -> LEDR=9'b100000000, Winner=00; a 5th LeftPulse -> LEDR=0, Winner=01, LeftScore=1.
REQ-028 From centre, LeftPulse and RightPulse high together for 3 cycles -> LEDR stays 9'b000010000 and scores unchanged.
REQ-029 In LWON, a RightPulse -> PLAY, LEDR=9'b000010000, RightScore unchanged; the following RightPulse -> LEDR=9'b000001000.
REQ-030 Right wins 7 rounds -> after the 7th, Winner=11 and RightScore=7; 10 further pulses of either kind -> no output change.
REQ-031 Reset asserted between clock edges at position 7 with LeftScore=3 -> outputs return to centre and zero scores before the next posedge.
REQ-032 With TUG_HEX_EN, LeftScore=2 -> HEX5=7'b0100100; without the macro, the design compiles with no HEX ports.
